// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write, read and scoreboard signals of the multi-port register file
interface reg_file_mp_if #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2
);
  localparam int AW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
  logic [NUM_WR-1:0]        wr_en_i;
  logic [NUM_WR*AW-1:0]     wr_addr_i;
  logic [NUM_WR*DATA_W-1:0] wr_data_i;
  logic [NUM_RD*AW-1:0]     rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     sb_set_i;
  logic [AW-1:0]            sb_addr_i;
  logic [REG_COUNT-1:0]     busy_vec_o;
  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, sb_set_i, sb_addr_i,
    input  rd_data_o, rd_busy_o, busy_vec_o
  );
  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, sb_set_i, sb_addr_i,
    output rd_data_o, rd_busy_o, busy_vec_o
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: N-read/M-write register file with per-register pending-write busy bits; define REG_FILE_BYPASS_EN for same-cycle write-to-read bypass
module reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int ZERO_REG  = 1
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_mp_if.slave bus
);
  localparam int AW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
  logic [DATA_W-1:0]        mem_q [REG_COUNT];
  logic [DATA_W-1:0]        mem_d [REG_COUNT];
  logic [REG_COUNT-1:0]     busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [AW-1:0]            ra;
  function automatic logic in_range(logic [AW-1:0] a);
    return int'(a) < REG_COUNT;
  endfunction
  function automatic logic writable(logic [AW-1:0] a);
    return in_range(a) && !(ZERO_REG != 0 && a == '0);
  endfunction
  // next state: writes in ascending port order so the highest index wins; issue set overrides a same-cycle clear
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++)
      if (bus.wr_en_i[p] && writable(bus.wr_addr_i[p*AW +: AW])) begin
        mem_d[bus.wr_addr_i[p*AW +: AW]]  = bus.wr_data_i[p*DATA_W +: DATA_W];
        busy_d[bus.wr_addr_i[p*AW +: AW]] = 1'b0;
      end
    if (bus.sb_set_i && writable(bus.sb_addr_i)) busy_d[bus.sb_addr_i] = 1'b1;
  end
  // register array and scoreboard, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end
  // combinational read ports; out-of-range addresses and reset force zero
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = bus.rd_addr_i[r*AW +: AW];
      if (rst_n && in_range(ra)) begin
        rd_data[r*DATA_W +: DATA_W] = mem_q[ra];
        rd_busy[r]                  = busy_q[ra];
`ifdef REG_FILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++)
          if (bus.wr_en_i[p] && bus.wr_addr_i[p*AW +: AW] == ra && writable(ra)) begin
            rd_data[r*DATA_W +: DATA_W] = bus.wr_data_i[p*DATA_W +: DATA_W];
            rd_busy[r]                  = bus.sb_set_i && bus.sb_addr_i == ra;
          end
`endif
      end
    end
  end
  assign bus.rd_data_o  = rd_data;
  assign bus.rd_busy_o  = rd_busy;
  assign bus.busy_vec_o = busy_q;
endmodule
